// File: rtl/cipher_pkg.sv
// Shared definitions for the 4-bit S-box block cipher datapath: nibble width,
// forward and inverse S-box tables, and the substitution-layer FSM states.
package cipher_pkg;

    localparam int NIBBLE_W = 4;

    // Forward S-box used by the encrypt path; entry x is S(x).
    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    // Inverse S-box used by the decrypt path; INV_SBOX[SBOX[x]] == x.
    localparam logic [3:0] INV_SBOX [16] = '{
        4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
        4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sbox_inv.sv
// Purely combinational 4-bit inverse S-box lookup.
module sbox_inv
    import cipher_pkg::*;
(
    input  logic [3:0] i_x,
    output logic [3:0] o_r
);

    assign o_r = INV_SBOX[i_x];

endmodule

// File: rtl/inv_sbox_layer.sv
// Sequential inverse substitution layer: accepts one state word, substitutes
// LANES nibbles per cycle (LSB group first) and presents the result until
// the downstream takes it.
module inv_sbox_layer
    import cipher_pkg::*;
#(
    parameter int BLOCK_W = 64,
    parameter int LANES   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               busy
);

    localparam int LANE_W = NIBBLE_W * LANES;
    localparam int NSTEP  = BLOCK_W / LANE_W;
    localparam int CNT_W  = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BLOCK_W-1:0] r_buf;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        w_base;
    logic [LANE_W-1:0]  w_lane_in;
    logic [LANE_W-1:0]  w_lane_out;
    logic               w_last;

    // Bit offset of the nibble group handled in the current step.
    assign w_base    = 32'(r_cnt) * 32'(LANE_W);
    assign w_lane_in = r_buf[w_base +: LANE_W];
    assign w_last    = (r_cnt == CNT_W'(NSTEP - 1));

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sbox_inv u_sbox_inv (
            .i_x (w_lane_in [g*NIBBLE_W +: NIBBLE_W]),
            .o_r (w_lane_out[g*NIBBLE_W +: NIBBLE_W])
        );
    end

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs, decoded from the registered state only.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: load the buffer on accept, then substitute one group per step.
    // NOTE: the buffer is reset because it drives out_data directly and must
    // read zero after reset; a partial result is discarded the same way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf <= '0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_buf <= in_data;
                        r_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    r_buf[w_base +: LANE_W] <= w_lane_out;
                    r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                end
                default: begin
                    r_buf <= r_buf;
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign out_data = r_buf;

endmodule

// File: tb/tb_inv_sbox_layer.sv
// Self-checking bench for inv_sbox_layer: table vectors at LANES=4 and
// LANES=1, backpressure, mid-run reset, and a randomized round trip through
// a forward S-box model.
module tb_inv_sbox_layer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid0 = 1'b0, in_ready0, out_valid0, out_ready0 = 1'b1, busy0;
    logic [63:0] in_data0 = '0, out_data0;
    logic        in_valid1 = 1'b0, in_ready1, out_valid1, out_ready1 = 1'b1, busy1;
    logic [63:0] in_data1 = '0, out_data1;

    int checks = 0;
    int errors = 0;

    logic [3:0] fwd_tbl [16];
    logic [3:0] inv_tbl [16];

    always #5 clk = ~clk;

    inv_sbox_layer #(.BLOCK_W(64), .LANES(4)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .busy(busy0)
    );

    inv_sbox_layer #(.BLOCK_W(64), .LANES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .busy(busy1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: substitute every nibble through a table.
    function automatic logic [63:0] subst(input logic [63:0] w, input bit inverse);
        logic [63:0] r;
        for (int k = 0; k < 16; k++) begin
            r[4*k +: 4] = inverse ? inv_tbl[w[4*k +: 4]] : fwd_tbl[w[4*k +: 4]];
        end
        return r;
    endfunction

    function automatic logic get_rdy(input int sel);
        return (sel == 0) ? in_ready0 : in_ready1;
    endfunction

    function automatic logic get_ov(input int sel);
        return (sel == 0) ? out_valid0 : out_valid1;
    endfunction

    function automatic logic [63:0] get_od(input int sel);
        return (sel == 0) ? out_data0 : out_data1;
    endfunction

    // Present a word and return #1 after the accepting edge.
    task automatic send(input int sel, input logic [63:0] d);
        logic acc;
        int   n;
        if (sel == 0) begin in_valid0 = 1'b1; in_data0 = d; end
        else          begin in_valid1 = 1'b1; in_data1 = d; end
        n = 0;
        do begin
            acc = get_rdy(sel);
            @(posedge clk);
            n++;
        end while (!acc && n < 200);
        #1;
        if (sel == 0) in_valid0 = 1'b0; else in_valid1 = 1'b0;
        if (!acc) check("send_timeout", 64'(n), 64'd0);
    endtask

    // Count cycles from the accepting edge to out_valid, then consume the result.
    task automatic recv(input int sel, output logic [63:0] d, output int lat);
        lat = 0;
        d   = '0;
        while (lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (get_ov(sel)) break;
        end
        d = get_od(sel);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [63:0] din;
        logic [63:0] dexp;
    } vec_t;

    initial begin
        vec_t        vecs [6];
        logic [63:0] d;
        int          lat;
        logic        seen;

        fwd_tbl = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
        for (int i = 0; i < 16; i++) inv_tbl[fwd_tbl[i]] = 4'(i);

        vecs[0] = '{64'h0000000000000000, 64'h5555555555555555};
        vecs[1] = '{64'h21748FE3DA09B65C, 64'hFEDCBA9876543210};
        vecs[2] = '{64'hFFFFFFFFFFFFFFFF, 64'hAAAAAAAAAAAAAAAA};
        vecs[3] = '{64'h0123456789ABCDEF, 64'h5EF8C12DB463079A};
        for (int i = 4; i < 6; i++) begin
            vecs[i].din  = {$urandom, $urandom};
            vecs[i].dexp = subst(vecs[i].din, 1'b1);
        end

        // Reset state.
        #12;
        check("rst_in_ready", 64'(in_ready0), 64'd1);
        check("rst_out_valid", 64'(out_valid0), 64'd0);
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_out_data", out_data0, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table vectors on both lane configurations.
        for (int i = 0; i < 6; i++) begin
            send(0, vecs[i].din);
            recv(0, d, lat);
            check($sformatf("vec%0d_l4_data", i), d, vecs[i].dexp);
            check($sformatf("vec%0d_l4_lat", i), 64'(lat), 64'd4);
            send(1, vecs[i].din);
            recv(1, d, lat);
            check($sformatf("vec%0d_l1_data", i), d, vecs[i].dexp);
            check($sformatf("vec%0d_l1_lat", i), 64'(lat), 64'd16);
        end

        // Backpressure with a new word waiting upstream.
        out_ready0 = 1'b0;
        send(0, 64'h21748FE3DA09B65C);
        lat = 0;
        while (!out_valid0 && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("bp_lat", 64'(lat), 64'd4);
        in_valid0 = 1'b1;
        in_data0  = 64'h0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", 64'(out_valid0), 64'd1);
            check("bp_out_data", out_data0, 64'hFEDCBA9876543210);
            check("bp_in_ready", 64'(in_ready0), 64'd0);
        end
        out_ready0 = 1'b1;
        @(posedge clk);
        #1;
        check("bp_handshake_ov", 64'(out_valid0), 64'd0);
        check("bp_handshake_busy", 64'(busy0), 64'd0);
        check("bp_handshake_rdy", 64'(in_ready0), 64'd1);
        @(posedge clk);
        #1;
        in_valid0 = 1'b0;
        check("bp_accept_busy", 64'(busy0), 64'd1);
        check("bp_accept_rdy", 64'(in_ready0), 64'd0);
        recv(0, d, lat);
        check("bp_next_data", d, 64'h5555555555555555);
        check("bp_next_lat", 64'(lat), 64'd4);

        // Reset two cycles after accept.
        send(0, 64'h21748FE3DA09B65C);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", 64'(in_ready0), 64'd1);
        check("mid_rst_out_valid", 64'(out_valid0), 64'd0);
        check("mid_rst_busy", 64'(busy0), 64'd0);
        check("mid_rst_out_data", out_data0, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid0 || busy0) seen = 1'b1;
        end
        check("post_rst_no_output", 64'(seen), 64'd0);

        // Randomized round trip with upstream gaps and downstream stalls.
        begin
            logic [63:0] q [$];
            int          got;
            int          cyc;
            bit          prod_done;
            got       = 0;
            cyc       = 0;
            prod_done = 1'b0;
            fork
                begin
                    for (int i = 0; i < 1000; i++) begin
                        logic [63:0] w;
                        w = {$urandom, $urandom};
                        repeat ($urandom_range(0, 2)) @(posedge clk);
                        #1;
                        q.push_back(w);
                        send(0, subst(w, 1'b0));
                    end
                    prod_done = 1'b1;
                end
                begin
                    while (got < 1000 && cyc < 40000) begin
                        logic hs;
                        out_ready0 = ($urandom_range(0, 3) != 0);
                        hs = out_valid0 && out_ready0;
                        d  = out_data0;
                        @(posedge clk);
                        #1;
                        cyc++;
                        if (hs) begin
                            if (q.size() == 0) begin
                                check("rt_duplicate", d, 64'hx);
                            end else begin
                                check($sformatf("rt_word%0d", got), d, q.pop_front());
                            end
                            got++;
                        end
                    end
                    out_ready0 = 1'b1;
                end
            join
            check("rt_count", 64'(got), 64'd1000);
            check("rt_producer_done", 64'(prod_done), 64'd1);
            check("rt_queue_empty", 64'(q.size()), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
